// File: rtl/shufflev_pkg.sv
// Shared types and helpers for the shufflev instruction-side bus guard.
package shufflev_pkg;

  typedef enum logic {
    BG_RUN,
    BG_ERR_RESP
  } bus_guard_state_e;

  localparam int BG_TIMEOUT_CNT_W = 8;

  // Unsigned wrap-around makes addresses below the base fail the compare too.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/shufflev_instr_bus_if.sv
// Request/grant + response instruction bus; the fetcher is the master, memory the slave.
interface shufflev_instr_bus_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/shufflev_resp_watchdog.sv
// Counts idle cycles while responses are owed and fires once the limit is reached.
module shufflev_resp_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic rvalid_i,
  output logic fire_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;

  // NOTE: defaults are assigned first so every path drives every output; no latch.
  always_comb begin
    fire_o = active_i && !rvalid_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_d   = wd_q + WD_W'(1);
    if (!active_i || rvalid_i || fire_o) wd_d = '0;
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wd_q <= '0;
    else       wd_q <= wd_d;
  end

endmodule

// File: rtl/shufflev_instr_bus_guard.sv
// Instruction bus guard: caps in-flight fetches, rejects out-of-window addresses in order,
// and converts lost memory responses into error responses.
module shufflev_instr_bus_guard
  import shufflev_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter logic [31:0] ADDR_BASE       = 32'h0010_0000,
  parameter logic [31:0] ADDR_SIZE       = 32'h0001_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  shufflev_instr_bus_if.slave         host,
  shufflev_instr_bus_if.master        mem,
  output logic [BG_TIMEOUT_CNT_W-1:0] timeout_cnt_o,
  output logic                        busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  bus_guard_state_e            state_q, state_d;
  logic [CW-1:0]               out_q, out_d;
  logic [CW-1:0]               drop_q, drop_d;
  logic [BG_TIMEOUT_CNT_W-1:0] tmo_q, tmo_d;

  logic          legal, credit, fire, fwd, inc, dec, err_state;
  logic          mem_req, host_gnt;
  logic [CW:0]   in_flight;

  assign legal     = in_window(host.addr, ADDR_BASE, ADDR_SIZE);
  assign in_flight = {1'b0, out_q} + {1'b0, drop_q};
  assign credit    = in_flight < (CW + 1)'(MAX_OUTSTANDING);
  assign err_state = (state_q == BG_ERR_RESP);

  shufflev_resp_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (out_q != '0),
    .rvalid_i (mem.rvalid),
    .fire_o   (fire)
  );

  // An illegal fetch is only granted once every real response has drained,
  // so its error response cannot overtake older data.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    host_gnt = 1'b0;
    unique case (state_q)
      BG_RUN: begin
        if (legal) begin
          mem_req  = host.req && credit;
          host_gnt = mem_req && mem.gnt;
        end else begin
          host_gnt = host.req && (out_q == '0);
          if (host_gnt) state_d = BG_ERR_RESP;
        end
      end
      BG_ERR_RESP: state_d = BG_RUN;
      default:     state_d = BG_RUN;
    endcase
  end

  always_comb begin
    fwd   = mem.rvalid && (drop_q == '0);
    inc   = mem_req && mem.gnt;
    dec   = fwd || fire;
    out_d = out_q + CW'(inc) - CW'(dec);

    drop_d = drop_q;
    if (fire)                              drop_d = drop_q + CW'(1);
    else if (mem.rvalid && drop_q != '0)   drop_d = drop_q - CW'(1);

    tmo_d = tmo_q;
    if (fire && tmo_q != '1) tmo_d = tmo_q + BG_TIMEOUT_CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BG_RUN;
      out_q   <= '0;
      drop_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem.req      = mem_req;
  assign mem.addr     = host.addr;
  assign host.gnt     = host_gnt;
  assign host.rvalid  = fwd || fire || err_state;
  assign host.rdata   = fwd ? mem.rdata : 32'h0;
  assign host.err     = fwd ? mem.err : (fire || err_state);
  assign timeout_cnt_o = tmo_q;
  assign busy_o       = (out_q != '0) || (drop_q != '0) || (state_q != BG_RUN);

  a_single_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({fwd, fire, err_state}));
  a_in_flight: assert property (@(posedge clk_i) disable iff (rst_i)
    in_flight <= (CW + 1)'(MAX_OUTSTANDING));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    dec |-> (out_q != '0));

endmodule

// File: tb/tb_shufflev_instr_bus_guard.sv
// Directed bench for shufflev_instr_bus_guard with a response scoreboard.
module tb_shufflev_instr_bus_guard;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] timeout_cnt;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  rsp_t exp_q[$];

  shufflev_instr_bus_if host ();
  shufflev_instr_bus_if mem ();

  shufflev_instr_bus_guard #(
    .MAX_OUTSTANDING (2),
    .TIMEOUT_CYCLES  (4),
    .ADDR_BASE       (32'h0010_0000),
    .ADDR_SIZE       (32'h0001_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host          (host.slave),
    .mem           (mem.master),
    .timeout_cnt_o (timeout_cnt),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host.req   = 1'b0;
    mem.gnt    = 1'b0;
    mem.rvalid = 1'b0;
    mem.rdata  = 32'h0;
    mem.err    = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic err);
    rsp_t r;
    r.data = data;
    r.err  = err;
    exp_q.push_back(r);
  endtask

  task automatic legal_req(input logic [31:0] addr);
    host.req  = 1'b1;
    host.addr = addr;
    mem.gnt   = 1'b1;
  endtask

  // Monitor: every host response must match the oldest expected entry.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (host.rvalid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: got data=%h err=%b, expected no response",
                   host.rdata, host.err);
        end else begin
          e = exp_q.pop_front();
          if (host.rdata !== e.data || host.err !== e.err) begin
            miscompares++;
            $display("FAIL rsp: got data=%h err=%b, expected data=%h err=%b",
                     host.rdata, host.err, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    host.addr = 32'h0;
    idle();
    @(negedge clk);
    check("rst_gnt",     host.gnt,    0);
    check("rst_rvalid",  host.rvalid, 0);
    check("rst_mem_req", mem.req,     0);
    check("rst_tmo",     timeout_cnt, 0);
    check("rst_busy",    busy,        0);
    step(); rst = 1'b0;
    step();

    // Single legal fetch, zero-latency grant, response one cycle later.
    legal_req(32'h0010_0000);
    @(negedge clk);
    check("t1_gnt",      host.gnt, 1);
    check("t1_mem_req",  mem.req,  1);
    check("t1_mem_addr", mem.addr, 32'h0010_0000);
    step(); idle(); mem.rvalid = 1'b1; mem.rdata = 32'hA5A5_0001; push(32'hA5A5_0001, 1'b0);
    @(negedge clk);
    check("t1_rvalid", host.rvalid, 1);
    step(); idle();
    @(negedge clk);
    check("t1_busy", busy, 0);

    // Credit limit: third back-to-back fetch stalls until a response returns.
    step(); legal_req(32'h0010_0004);
    @(negedge clk); check("t2_gnt_a", host.gnt, 1);
    step(); host.addr = 32'h0010_0008;
    @(negedge clk); check("t2_gnt_b", host.gnt, 1);
    step(); host.addr = 32'h0010_000C;
    @(negedge clk); check("t2_stall_gnt_c", host.gnt, 0); check("t2_stall_req_c", mem.req, 0);
    step();
    @(negedge clk); check("t2_stall_gnt_d", host.gnt, 0); check("t2_stall_req_d", mem.req, 0);
    step(); mem.rvalid = 1'b1; mem.rdata = 32'hB0B0_0004; push(32'hB0B0_0004, 1'b0);
    @(negedge clk); check("t2_stall_gnt_e", host.gnt, 0);
    step(); mem.rvalid = 1'b0;
    @(negedge clk); check("t2_gnt_f", host.gnt, 1); check("t2_req_f", mem.req, 1);
    step(); idle(); mem.rvalid = 1'b1; mem.rdata = 32'hC0C0_0008; push(32'hC0C0_0008, 1'b0);
    step(); mem.rdata = 32'hD0D0_000C; push(32'hD0D0_000C, 1'b0);
    step(); idle();
    @(negedge clk); check("t2_busy", busy, 0);

    // Out-of-window fetch waits for the real response, then errors in order.
    step(); legal_req(32'h0010_0010);
    @(negedge clk); check("t3_gnt_legal", host.gnt, 1);
    step(); host.addr = 32'h0000_0400;
    @(negedge clk); check("t3_hold_gnt_b", host.gnt, 0); check("t3_req_b", mem.req, 0);
    step();
    @(negedge clk); check("t3_hold_gnt_c", host.gnt, 0); check("t3_req_c", mem.req, 0);
    step(); mem.rvalid = 1'b1; mem.rdata = 32'hE0E0_0010; push(32'hE0E0_0010, 1'b0);
    @(negedge clk); check("t3_hold_gnt_d", host.gnt, 0); check("t3_req_d", mem.req, 0);
    step(); mem.rvalid = 1'b0; mem.rdata = 32'h0; push(32'h0, 1'b1);
    @(negedge clk); check("t3_gnt_err", host.gnt, 1); check("t3_req_e", mem.req, 0);
    step(); idle();
    @(negedge clk); check("t3_err_rvalid", host.rvalid, 1); check("t3_req_f", mem.req, 0);
    step();
    @(negedge clk); check("t3_busy", busy, 0);

    // Watchdog fires four cycles after the grant; late response is dropped.
    step(); legal_req(32'h0010_0020); push(32'h0, 1'b1);
    @(negedge clk); check("t4_gnt", host.gnt, 1);
    step(); idle();
    step();
    step();
    @(negedge clk); check("t4_no_early_fire", host.rvalid, 0);
    step();
    @(negedge clk); check("t4_fire", host.rvalid, 1); check("t4_fire_err", host.err, 1);
    step(); mem.rvalid = 1'b1; mem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_late_dropped", host.rvalid, 0);
    check("t4_tmo_cnt", timeout_cnt, 1);
    check("t4_busy_drop", busy, 1);
    step(); idle();
    @(negedge clk); check("t4_busy_after", busy, 0);

    // Response arriving in the would-be fire cycle wins over the watchdog.
    step(); legal_req(32'h0010_0030);
    @(negedge clk); check("t5_gnt", host.gnt, 1);
    step(); idle();
    step();
    step();
    step(); mem.rvalid = 1'b1; mem.rdata = 32'hF0F0_0030; push(32'hF0F0_0030, 1'b0);
    @(negedge clk); check("t5_err", host.err, 0); check("t5_tmo_cnt", timeout_cnt, 1);
    step(); idle();
    @(negedge clk); check("t5_tmo_after", timeout_cnt, 1); check("t5_busy", busy, 0);

    // Reset mid-operation with one request in flight and one drop pending.
    step(); legal_req(32'h0010_0040); push(32'h0, 1'b1);
    step(); idle();
    step();
    step();
    step();
    @(negedge clk); check("t6_fire", host.rvalid, 1);
    step(); legal_req(32'h0010_0044);
    @(negedge clk); check("t6_gnt_with_drop", host.gnt, 1);
    step(); idle();
    @(negedge clk); check("t6_busy_pre", busy, 1); check("t6_tmo_pre", timeout_cnt, 2);
    step(); rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy",   busy,        0);
    check("t6_rst_tmo",    timeout_cnt, 0);
    check("t6_rst_rvalid", host.rvalid, 0);
    check("t6_rst_req",    mem.req,     0);
    step(); rst = 1'b0;
    step(); legal_req(32'h0010_0048);
    @(negedge clk); check("t6_gnt_after_rst", host.gnt, 1);
    step(); idle(); mem.rvalid = 1'b1; mem.rdata = 32'h1234_0048; push(32'h1234_0048, 1'b0);
    step(); idle();
    @(negedge clk); check("t6_busy_end", busy, 0);

    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
